xor_stream_packer: RTL

Downstream consumer of the 1-bit XOR stage output. Collects the serial result bits into `WIDTH`-bit words, LSB first. Each word carries a bit count and the running XOR-parity of its bits. Words are presented on a valid/ready output port, so the XOR datapath can run bit-per-cycle into a word-oriented sink without bubbles.

---
 rtl/xor_stream_pkg.sv | 18 +
 rtl/xor_stream_packer_slot.sv | 38 +++
 rtl/xor_stream_packer.sv | 100 ++++++++++
 3 files changed

// File: rtl/xor_stream_pkg.sv
// rtl/xor_stream_pkg.sv - shared state enum, width bounds and count-width helper for the packer
package xor_stream_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        FLUSH   = 2'd2
    } packer_state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Count field must represent 0..width inclusive.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/xor_stream_packer_slot.sv
// rtl/xor_stream_packer_slot.sv - single registered output word with load/drain handling
module packer_slot
    import xor_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CW-1:0]    load_count,
    input  logic             load_parity,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_parity
);

    // Caller only asserts load when the slot is free, so a load always wins over a drain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
            out_parity <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= load_data;
            out_count  <= load_count;
            out_parity <= load_parity;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/xor_stream_packer.sv
// rtl/xor_stream_packer.sv - packs serial XOR-stage bits LSB first into counted, parity-tagged words
module xor_stream_packer
    import xor_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_parity
);

    packer_state_e    state, state_nxt;
    logic [WIDTH-1:0] col, col_acc, col_nxt;
    logic [CW-1:0]    cnt, cnt_acc, cnt_nxt;
    logic             par, par_acc, par_nxt;
    logic             accept, slot_free, full, load;

    assign in_ready  = reset_n && (state == COLLECT);
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;

    // Collector contents including this cycle's bit, so completion and flush see it.
    assign col_acc = accept ? (col | ({{(WIDTH-1){1'b0}}, in_data} << cnt)) : col;
    assign cnt_acc = cnt + CW'(accept);
    assign par_acc = par ^ (accept && in_data);
    assign full    = accept && (cnt_acc == CW'(WIDTH));

    always_comb begin
        state_nxt = state;
        col_nxt   = col_acc;
        cnt_nxt   = cnt_acc;
        par_nxt   = par_acc;
        load      = 1'b0;
        case (state)
            COLLECT: begin
                if (full || (flush && cnt_acc != '0)) begin
                    if (slot_free) begin
                        load    = 1'b1;
                        col_nxt = '0;
                        cnt_nxt = '0;
                        par_nxt = 1'b0;
                    end else begin
                        state_nxt = full ? HOLD : FLUSH;
                    end
                end
            end
            HOLD, FLUSH: begin
                if (slot_free) begin
                    load      = 1'b1;
                    col_nxt   = '0;
                    cnt_nxt   = '0;
                    par_nxt   = 1'b0;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= COLLECT;
            col   <= '0;
            cnt   <= '0;
            par   <= 1'b0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            cnt   <= cnt_nxt;
            par   <= par_nxt;
        end
    end

    packer_slot #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_slot (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (load),
        .load_data   (col_acc),
        .load_count  (cnt_acc),
        .load_parity (par_acc),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_parity  (out_parity)
    );

endmodule
